// File: rtl/cpu_mu0_param.sv
// MU0 accumulator CPU; optional MUL opcode enabled by macro CPU_MU0_MUL_EN.
// Latency: LDA/ADD/SUB(/MUL) 3 cycles, other ops 2 cycles, STP halts until rst.
// Backpressure: waitrequest freezes all state and bus outputs while a read/write is pending.
module cpu_mu0_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  running,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  waitrequest,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {FETCH, EXEC, DATA, HALTED} state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd8;
`ifdef CPU_MU0_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   ir;
    logic                    ir_ld;
    logic [DATA_WIDTH-1:0]   instr;
    logic [3:0]              opcode;
    logic [3:0]              ir_op;
    logic [ADDR_WIDTH-1:0]   operand;
    logic                    mem_rd_op;
    logic                    stall;

    // The instruction is only on readdata in the first EXEC cycle; a stalled EXEC replays it from ir.
    assign instr     = ir_ld ? ir : readdata;
    assign opcode    = instr[DATA_WIDTH-1 -: 4];
    assign operand   = instr[ADDR_WIDTH-1:0];
    assign ir_op     = ir[DATA_WIDTH-1 -: 4];
    assign writedata = acc;

    always_comb begin
        mem_rd_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
`ifdef CPU_MU0_MUL_EN
        if (opcode == OP_MUL) begin
            mem_rd_op = 1'b1;
        end
`endif
    end

    always_comb begin
        address = pc;
        read    = 1'b0;
        write   = 1'b0;
        case (state)
            FETCH: read = 1'b1;
            EXEC: begin
                if (mem_rd_op) begin
                    address = operand;
                    read    = 1'b1;
                end else if (opcode == OP_STO) begin
                    address = operand;
                    write   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall = waitrequest & (read | write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            ir_ld     <= 1'b0;
            running   <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (!stall) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    ir    <= instr;
                    ir_ld <= stall;
                    if (!stall) begin
                        state <= FETCH;
                        if (mem_rd_op) begin
                            state <= DATA;
                        end else begin
                            case (opcode)
                                OP_STO: pc <= pc + PC_ONE;
                                OP_JMP: pc <= operand;
                                OP_JGE: pc <= acc[DATA_WIDTH-1] ? pc + PC_ONE : operand;
                                OP_JNE: pc <= (acc != '0) ? operand : pc + PC_ONE;
                                OP_STP: begin
                                    state   <= HALTED;
                                    running <= 1'b0;
                                end
                                OP_OUT: begin
                                    out_valid <= 1'b1;
                                    out_data  <= acc;
                                    pc        <= pc + PC_ONE;
                                end
                                default: pc <= pc + PC_ONE;
                            endcase
                        end
                    end
                end
                DATA: begin
                    case (ir_op)
                        OP_LDA: acc <= readdata;
                        OP_ADD: acc <= acc + readdata;
                        OP_SUB: acc <= acc - readdata;
`ifdef CPU_MU0_MUL_EN
                        OP_MUL: acc <= acc * readdata;
`endif
                        default: acc <= acc;
                    endcase
                    pc    <= pc + PC_ONE;
                    state <= FETCH;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule
